// File: rtl/ex_mc.sv
// ex_mc: MIPS32 execute stage with logic, shift, add/sub, multiply and divide.
// Define EX_DIV_EN to build the iterative radix-2 divider.
module ex_mc #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush_i,
  input  logic [7:0]       aluop_i,
  input  logic [2:0]       alusel_i,
  input  logic [WIDTH-1:0] reg1_i,
  input  logic [WIDTH-1:0] reg2_i,
  input  logic [4:0]       wd_i,
  input  logic             wreg_i,
  output logic [4:0]       wd_o,
  output logic             wreg_o,
  output logic [WIDTH-1:0] wdata_o,
  output logic             whilo_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic             stallreq_o
);

  localparam int SW  = $clog2(WIDTH);
  localparam int MSB = WIDTH - 1;

  localparam logic [7:0] OP_AND   = 8'b0010_0100;
  localparam logic [7:0] OP_OR    = 8'b0010_0101;
  localparam logic [7:0] OP_XOR   = 8'b0010_0110;
  localparam logic [7:0] OP_NOR   = 8'b0010_0111;
  localparam logic [7:0] OP_SLL   = 8'b0111_1100;
  localparam logic [7:0] OP_SRL   = 8'b0000_0010;
  localparam logic [7:0] OP_SRA   = 8'b0000_0011;
  localparam logic [7:0] OP_ADD   = 8'b0010_0000;
  localparam logic [7:0] OP_ADDU  = 8'b0010_0001;
  localparam logic [7:0] OP_SUB   = 8'b0010_0010;
  localparam logic [7:0] OP_SUBU  = 8'b0010_0011;
  localparam logic [7:0] OP_SLT   = 8'b0010_1010;
  localparam logic [7:0] OP_SLTU  = 8'b0010_1011;
  localparam logic [7:0] OP_MULT  = 8'b0001_1000;
  localparam logic [7:0] OP_MULTU = 8'b0001_1001;
`ifdef EX_DIV_EN
  localparam logic [7:0] OP_DIV   = 8'b0001_1010;
  localparam logic [7:0] OP_DIVU  = 8'b0001_1011;
`endif

  localparam logic [2:0] SEL_LOGIC = 3'b001;
  localparam logic [2:0] SEL_SHIFT = 3'b010;
  localparam logic [2:0] SEL_ARITH = 3'b100;

  logic [WIDTH-1:0] logic_res;
  logic [WIDTH-1:0] shift_res;
  logic [WIDTH-1:0] arith_res;
  logic [SW-1:0]    shamt;

  always_comb begin
    logic_res = '0;
    case (aluop_i)
      OP_AND:  logic_res = reg1_i & reg2_i;
      OP_OR:   logic_res = reg1_i | reg2_i;
      OP_XOR:  logic_res = reg1_i ^ reg2_i;
      OP_NOR:  logic_res = ~(reg1_i | reg2_i);
      default: logic_res = '0;
    endcase
  end

  assign shamt = reg1_i[SW-1:0];

  always_comb begin
    shift_res = '0;
    case (aluop_i)
      OP_SLL:  shift_res = reg2_i << shamt;
      OP_SRL:  shift_res = reg2_i >> shamt;
      OP_SRA:  shift_res = $signed(reg2_i) >>> shamt;
      default: shift_res = '0;
    endcase
  end

  logic             is_sub;
  logic [WIDTH-1:0] opb;
  logic [WIDTH-1:0] sum;
  logic             ovf;
  logic             trap;

  assign is_sub = (aluop_i == OP_SUB) || (aluop_i == OP_SUBU);
  assign opb    = is_sub ? ~reg2_i : reg2_i;
  assign sum    = reg1_i + opb + WIDTH'(is_sub);
  // same-sign operands producing a flipped sign
  assign ovf    = (reg1_i[MSB] == opb[MSB]) && (sum[MSB] != reg1_i[MSB]);
  assign trap   = ovf && ((aluop_i == OP_ADD) || (aluop_i == OP_SUB));

  always_comb begin
    arith_res = '0;
    case (aluop_i)
      OP_ADD, OP_ADDU, OP_SUB, OP_SUBU:
        arith_res = sum;
      OP_SLT:
        arith_res = {{(WIDTH-1){1'b0}}, $signed(reg1_i) < $signed(reg2_i)};
      OP_SLTU:
        arith_res = {{(WIDTH-1){1'b0}}, reg1_i < reg2_i};
      default:
        arith_res = '0;
    endcase
  end

  logic                 is_mult;
  logic                 mul_en;
  logic [2*WIDTH-1:0]   mul_a;
  logic [2*WIDTH-1:0]   mul_b;
  logic [2*WIDTH-1:0]   prod;

  assign is_mult = aluop_i == OP_MULT;
  assign mul_en  = is_mult || (aluop_i == OP_MULTU);
  assign mul_a   = {{WIDTH{is_mult & reg1_i[MSB]}}, reg1_i};
  assign mul_b   = {{WIDTH{is_mult & reg2_i[MSB]}}, reg2_i};
  assign prod    = mul_a * mul_b;

`ifdef EX_DIV_EN
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nx;
  logic [SW-1:0]    cnt, cnt_nx;
  logic [WIDTH-1:0] rem, rem_nx;
  logic [WIDTH-1:0] quo, quo_nx;
  logic [WIDTH-1:0] dvs, dvs_nx;
  logic             neg_q, neg_q_nx;
  logic             neg_r, neg_r_nx;
  logic             is_div;
  logic             sgn_div;
  logic             div_stall;
  logic             div_done;
  logic [WIDTH:0]   shl;
  logic [WIDTH-1:0] diff;
  logic             fits;
  logic [WIDTH-1:0] div_hi;
  logic [WIDTH-1:0] div_lo;

  assign sgn_div = aluop_i == OP_DIV;
  assign is_div  = sgn_div || (aluop_i == OP_DIVU);
  assign shl     = {rem, quo[MSB]};
  assign fits    = shl >= {1'b0, dvs};
  assign diff    = shl[WIDTH-1:0] - dvs;
  assign div_hi  = neg_r ? -rem : rem;
  assign div_lo  = neg_q ? -quo : quo;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
      rem   <= '0;
      quo   <= '0;
      dvs   <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      rem   <= rem_nx;
      quo   <= quo_nx;
      dvs   <= dvs_nx;
      neg_q <= neg_q_nx;
      neg_r <= neg_r_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    rem_nx    = rem;
    quo_nx    = quo;
    dvs_nx    = dvs;
    neg_q_nx  = neg_q;
    neg_r_nx  = neg_r;
    div_stall = 1'b0;
    div_done  = 1'b0;
    unique case (state)
      IDLE: begin
        if (is_div && !flush_i) begin
          div_stall = 1'b1;
          cnt_nx    = '0;
          if (reg2_i == '0) begin
            quo_nx   = '1;
            rem_nx   = reg1_i;
            neg_q_nx = 1'b0;
            neg_r_nx = 1'b0;
            state_nx = DONE;
          end else begin
            neg_q_nx = sgn_div & (reg1_i[MSB] ^ reg2_i[MSB]);
            neg_r_nx = sgn_div & reg1_i[MSB];
            quo_nx   = (sgn_div && reg1_i[MSB]) ? -reg1_i : reg1_i;
            dvs_nx   = (sgn_div && reg2_i[MSB]) ? -reg2_i : reg2_i;
            rem_nx   = '0;
            state_nx = RUN;
          end
        end
      end
      RUN: begin
        div_stall = 1'b1;
        cnt_nx    = cnt + 1'b1;
        // quotient bits shift in from the right as dividend bits shift out
        if (fits) begin
          rem_nx = diff;
          quo_nx = {quo[WIDTH-2:0], 1'b1};
        end else begin
          rem_nx = shl[WIDTH-1:0];
          quo_nx = {quo[WIDTH-2:0], 1'b0};
        end
        if (cnt == SW'(WIDTH - 1)) state_nx = DONE;
      end
      DONE: begin
        div_done = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
    if (flush_i) begin
      state_nx  = IDLE;
      div_stall = 1'b0;
      div_done  = 1'b0;
    end
  end
`else
  logic unused_clk;
  assign unused_clk = clk;
`endif

  always_comb begin
    wd_o       = '0;
    wreg_o     = 1'b0;
    wdata_o    = '0;
    whilo_o    = 1'b0;
    hi_o       = '0;
    lo_o       = '0;
    stallreq_o = 1'b0;
    if (rst) begin
      wd_o   = wd_i;
      wreg_o = wreg_i & ~trap;
      unique case (alusel_i)
        SEL_LOGIC: wdata_o = logic_res;
        SEL_SHIFT: wdata_o = shift_res;
        SEL_ARITH: wdata_o = arith_res;
        default:   wdata_o = '0;
      endcase
      if (mul_en) begin
        whilo_o = 1'b1;
        hi_o    = prod[2*WIDTH-1:WIDTH];
        lo_o    = prod[WIDTH-1:0];
      end
`ifdef EX_DIV_EN
      stallreq_o = div_stall;
      if (div_done) begin
        whilo_o = 1'b1;
        hi_o    = div_hi;
        lo_o    = div_lo;
      end
`endif
      if (flush_i) begin
        whilo_o    = 1'b0;
        stallreq_o = 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ex_mc.sv
// tb_ex_mc: directed vectors for ex_mc, checked each cycle against a
// cycle-count reference model plus hand-computed literal expectations.
module tb_ex_mc;

  localparam int W = 32;
`ifdef EX_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  localparam logic [7:0] OP_AND   = 8'b0010_0100;
  localparam logic [7:0] OP_OR    = 8'b0010_0101;
  localparam logic [7:0] OP_XOR   = 8'b0010_0110;
  localparam logic [7:0] OP_NOR   = 8'b0010_0111;
  localparam logic [7:0] OP_SLL   = 8'b0111_1100;
  localparam logic [7:0] OP_SRL   = 8'b0000_0010;
  localparam logic [7:0] OP_SRA   = 8'b0000_0011;
  localparam logic [7:0] OP_ADD   = 8'b0010_0000;
  localparam logic [7:0] OP_ADDU  = 8'b0010_0001;
  localparam logic [7:0] OP_SUB   = 8'b0010_0010;
  localparam logic [7:0] OP_SUBU  = 8'b0010_0011;
  localparam logic [7:0] OP_SLT   = 8'b0010_1010;
  localparam logic [7:0] OP_SLTU  = 8'b0010_1011;
  localparam logic [7:0] OP_MULT  = 8'b0001_1000;
  localparam logic [7:0] OP_MULTU = 8'b0001_1001;
  localparam logic [7:0] OP_DIV   = 8'b0001_1010;
  localparam logic [7:0] OP_DIVU  = 8'b0001_1011;

  logic         clk = 1'b0;
  logic         rst;
  logic         flush_i;
  logic [7:0]   aluop_i;
  logic [2:0]   alusel_i;
  logic [W-1:0] reg1_i;
  logic [W-1:0] reg2_i;
  logic [4:0]   wd_i;
  logic         wreg_i;
  logic [4:0]   wd_o;
  logic         wreg_o;
  logic [W-1:0] wdata_o;
  logic         whilo_o;
  logic [W-1:0] hi_o;
  logic [W-1:0] lo_o;
  logic         stallreq_o;

  ex_mc #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush_i   (flush_i),
    .aluop_i   (aluop_i),
    .alusel_i  (alusel_i),
    .reg1_i    (reg1_i),
    .reg2_i    (reg2_i),
    .wd_i      (wd_i),
    .wreg_i    (wreg_i),
    .wd_o      (wd_o),
    .wreg_o    (wreg_o),
    .wdata_o   (wdata_o),
    .whilo_o   (whilo_o),
    .hi_o      (hi_o),
    .lo_o      (lo_o),
    .stallreq_o(stallreq_o)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Divide model: t counts cycles since issue, len is the stall length.
  int          t = 0;
  int          len = 1;
  logic [31:0] dq = '0;
  logic [31:0] dr = '0;

  function automatic logic [63:0] div_ref(input logic [7:0] op,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
    longint sa, sb, q, r;
    if (b == 0) return {a, 32'hFFFF_FFFF};
    if (op == OP_DIVU) return {a % b, a / b};
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    q  = sa / sb;
    r  = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  function automatic bit is_div(input logic [7:0] op);
    return op == OP_DIV || op == OP_DIVU;
  endfunction

  always @(posedge clk) begin
    if (!rst || flush_i) t <= 0;
    else if (t == 0) begin
      if (DIV_EN && is_div(aluop_i)) begin
        t   <= 1;
        len <= (reg2_i == 0) ? 1 : W + 1;
        {dr, dq} <= div_ref(aluop_i, reg1_i, reg2_i);
      end
    end else if (t == len) t <= 0;
    else t <= t + 1;
  end

  typedef struct packed {
    logic [4:0]  wd;
    logic        wreg;
    logic [31:0] wdata;
    logic        whilo;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        stall;
  } out_t;

  function automatic out_t expect_now();
    out_t        e;
    longint      s;
    logic [63:0] p;
    logic [31:0] a, b;
    logic [4:0]  sh;
    bit          mul, done;
    e = '0;
    if (!rst) return e;
    a  = reg1_i;
    b  = reg2_i;
    sh = a[4:0];
    s  = 0;
    if (aluop_i == OP_ADD) s = longint'($signed(a)) + longint'($signed(b));
    if (aluop_i == OP_SUB) s = longint'($signed(a)) - longint'($signed(b));
    e.wd   = wd_i;
    e.wreg = wreg_i && (s == longint'($signed(s[31:0])));
    case (alusel_i)
      3'b001: case (aluop_i)
        OP_AND:  e.wdata = a & b;
        OP_OR:   e.wdata = a | b;
        OP_XOR:  e.wdata = a ^ b;
        OP_NOR:  e.wdata = ~(a | b);
        default: e.wdata = 0;
      endcase
      3'b010: case (aluop_i)
        OP_SLL:  e.wdata = b << sh;
        OP_SRL:  e.wdata = b >> sh;
        OP_SRA:  e.wdata = $signed(b) >>> sh;
        default: e.wdata = 0;
      endcase
      3'b100: case (aluop_i)
        OP_ADD, OP_ADDU: e.wdata = a + b;
        OP_SUB, OP_SUBU: e.wdata = a - b;
        OP_SLT:  e.wdata = ($signed(a) < $signed(b)) ? 1 : 0;
        OP_SLTU: e.wdata = (a < b) ? 1 : 0;
        default: e.wdata = 0;
      endcase
      default: e.wdata = 0;
    endcase
    p   = 0;
    mul = 1'b0;
    if (aluop_i == OP_MULT) begin
      s   = longint'($signed(a)) * longint'($signed(b));
      p   = s;
      mul = 1'b1;
    end
    if (aluop_i == OP_MULTU) begin
      p   = {32'b0, a} * {32'b0, b};
      mul = 1'b1;
    end
    done    = (t != 0) && (t == len) && !flush_i;
    e.stall = !flush_i &&
              ((t == 0 && DIV_EN && is_div(aluop_i)) || (t != 0 && t < len));
    e.whilo = !flush_i && (mul || done);
    if (done) begin
      e.hi = dr;
      e.lo = dq;
    end else if (mul) begin
      e.hi = p[63:32];
      e.lo = p[31:0];
    end
    return e;
  endfunction

  always @(negedge clk) begin
    out_t e;
    e = expect_now();
    chk("m_wd", wd_o, e.wd);
    chk("m_wreg", wreg_o, e.wreg);
    chk("m_wdata", wdata_o, e.wdata);
    chk("m_whilo", whilo_o, e.whilo);
    chk("m_hi", hi_o, e.hi);
    chk("m_lo", lo_o, e.lo);
    chk("m_stall", stallreq_o, e.stall);
  end

  task automatic apply(input logic [7:0] op, input logic [2:0] sel,
                       input logic [31:0] a, input logic [31:0] b);
    @(posedge clk);
    #1;
    aluop_i  = op;
    alusel_i = sel;
    reg1_i   = a;
    reg2_i   = b;
  endtask

  task automatic vec(input string name, input logic [7:0] op,
                     input logic [2:0] sel, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] exp_wdata,
                     input logic exp_wreg);
    apply(op, sel, a, b);
    @(negedge clk);
    chk({name, "_wdata"}, wdata_o, exp_wdata);
    chk({name, "_wreg"}, wreg_o, exp_wreg);
  endtask

  task automatic mvec(input string name, input logic [7:0] op,
                      input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    apply(op, 3'b000, a, b);
    @(negedge clk);
    chk({name, "_hi"}, hi_o, exp_hi);
    chk({name, "_lo"}, lo_o, exp_lo);
    chk({name, "_whilo"}, whilo_o, 1);
    chk({name, "_stall"}, stallreq_o, 0);
  endtask

  task automatic do_div(input string name, input logic [7:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input int exp_n, input logic [31:0] exp_hi,
                        input logic [31:0] exp_lo);
    int n = 0;
    apply(op, 3'b000, a, b);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!stallreq_o) break;
      n++;
    end
    chk({name, "_stalls"}, n, DIV_EN ? exp_n : 0);
    chk({name, "_whilo"}, whilo_o, DIV_EN ? 1 : 0);
    chk({name, "_hi"}, hi_o, DIV_EN ? exp_hi : 32'h0);
    chk({name, "_lo"}, lo_o, DIV_EN ? exp_lo : 32'h0);
  endtask

  task automatic all_zero(input string name);
    chk({name, "_wd"}, wd_o, 0);
    chk({name, "_wreg"}, wreg_o, 0);
    chk({name, "_wdata"}, wdata_o, 0);
    chk({name, "_whilo"}, whilo_o, 0);
    chk({name, "_hi"}, hi_o, 0);
    chk({name, "_lo"}, lo_o, 0);
    chk({name, "_stall"}, stallreq_o, 0);
  endtask

  initial begin
    int pulses;
    rst      = 1'b0;
    flush_i  = 1'b0;
    aluop_i  = OP_OR;
    alusel_i = 3'b001;
    reg1_i   = 32'h0000_F0F0;
    reg2_i   = 32'h0000_0F0F;
    wd_i     = 5'd9;
    wreg_i   = 1'b1;
    repeat (2) @(negedge clk);
    all_zero("reset");

    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("or_wdata", wdata_o, 32'h0000_FFFF);
    chk("or_wreg", wreg_o, 1);
    chk("or_wd", wd_o, 9);

    vec("or_nop", OP_OR, 3'b000, 32'h0000_F0F0, 32'h0000_0F0F, 32'h0, 1'b1);
    vec("add_ovf", OP_ADD, 3'b100, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 1'b0);
    vec("addu", OP_ADDU, 3'b100, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 1'b1);
    vec("sub_ovf", OP_SUB, 3'b100, 32'h8000_0000, 32'h1, 32'h7FFF_FFFF, 1'b0);
    vec("sub_ok", OP_SUB, 3'b100, 32'h5, 32'h7, 32'hFFFF_FFFE, 1'b1);
    vec("subu", OP_SUBU, 3'b100, 32'h5, 32'h7, 32'hFFFF_FFFE, 1'b1);
    vec("sra", OP_SRA, 3'b010, 32'h4, 32'h8000_0010, 32'hF800_0001, 1'b1);
    vec("srl", OP_SRL, 3'b010, 32'h4, 32'h8000_0010, 32'h0800_0001, 1'b1);
    vec("sll_wrap", OP_SLL, 3'b010, 32'd36, 32'h1, 32'h10, 1'b1);
    vec("slt", OP_SLT, 3'b100, 32'hFFFF_FFFF, 32'h1, 32'h1, 1'b1);
    vec("sltu", OP_SLTU, 3'b100, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b1);
    vec("and", OP_AND, 3'b001, 32'hFF00_FF00, 32'h0FF0_0FF0, 32'h0F00_0F00, 1'b1);
    vec("xor", OP_XOR, 3'b001, 32'hFF00_FF00, 32'h0FF0_0FF0, 32'hF0F0_F0F0, 1'b1);
    vec("nor", OP_NOR, 3'b001, 32'hFF00_FF00, 32'h0FF0_0FF0, 32'h000F_000F, 1'b1);
    vec("unk_op", 8'hFF, 3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 1'b1);
    vec("bad_sel", OP_ADD, 3'b011, 32'h1, 32'h1, 32'h0, 1'b1);

    mvec("mult", OP_MULT, 32'hFFFF_FFFF, 32'h2, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    mvec("multu", OP_MULTU, 32'hFFFF_FFFF, 32'h2, 32'h1, 32'hFFFF_FFFE);

    do_div("div_m7_2", OP_DIV, 32'hFFFF_FFF9, 32'h2, 33,
           32'hFFFF_FFFF, 32'hFFFF_FFFD);
    do_div("divu_7_0", OP_DIVU, 32'h7, 32'h0, 1, 32'h7, 32'hFFFF_FFFF);
    do_div("div_7_m2", OP_DIV, 32'h7, 32'hFFFF_FFFE, 33, 32'h1, 32'hFFFF_FFFD);
    do_div("div_min_m1", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 33,
           32'h0, 32'h8000_0000);
    do_div("divu_max_1", OP_DIVU, 32'hFFFF_FFFF, 32'h1, 33,
           32'h0, 32'hFFFF_FFFF);
    do_div("divu_100_3", OP_DIVU, 32'd100, 32'd3, 33, 32'd1, 32'd33);

    apply(OP_DIVU, 3'b000, 32'd100, 32'd3);
    repeat (9) @(posedge clk);
    @(negedge clk);
    chk("flush_pre_stall", stallreq_o, DIV_EN ? 1 : 0);
    @(posedge clk);
    #1 flush_i = 1'b1;
    @(negedge clk);
    chk("flush_stall", stallreq_o, 0);
    chk("flush_whilo", whilo_o, 0);
    @(posedge clk);
    #1;
    flush_i  = 1'b0;
    aluop_i  = 8'h00;
    alusel_i = 3'b000;
    pulses   = 0;
    repeat (40) begin
      @(negedge clk);
      if (whilo_o) pulses++;
    end
    chk("flush_no_whilo", pulses, 0);

    apply(OP_DIVU, 3'b000, 32'd100, 32'd3);
    repeat (5) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    all_zero("rst_mid");
    @(posedge clk);
    #1;
    rst      = 1'b1;
    aluop_i  = 8'h00;
    alusel_i = 3'b000;
    @(negedge clk);
    chk("rst_after_stall", stallreq_o, 0);
    chk("rst_after_whilo", whilo_o, 0);

    do_div("divu_again", OP_DIVU, 32'd100, 32'd3, 33, 32'd1, 32'd33);
    apply(8'h00, 3'b000, 32'h0, 32'h0);
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ex_mc.md
# ex_mc

Parametrised multi-cycle execute stage for the MIPS32 pipeline. It sits between ID/EX and EX/MEM and covers logic, shift, add/sub/compare, single-cycle multiply and an iterative radix-2 divider. The divider stalls the pipeline until its result is ready. Register and HI/LO write-back requests are forwarded to EX/MEM.

## Interface
- WIDTH, 32: datapath width; must be a power of two, ≥8.
- clk  in  1  pipeline clock; all state updates on rising edge.
- rst  in  1  synchronous reset, active-low (rst==0 at a rising edge resets).
- flush_i  in  1  cancels any in-flight divide.
- aluop_i  in  8  operation code (`AluOpBus`).
- alusel_i  in  3  result class (`AluSelBus`).
- reg1_i, reg2_i  in  WIDTH  operands.
- wd_i  in  5  destination register address.
- wreg_i  in  1  destination write enable.
- wd_o  out  5  equals wd_i.
- wreg_o  out  1  wreg_i, cleared on signed overflow.
- wdata_o  out  WIDTH  GPR result.
- whilo_o  out  1  HI/LO write request.
- hi_o, lo_o  out  WIDTH  HI/LO write data.
- stallreq_o  out  1  holds the pipeline while a divide runs.

## Operation
- Opcodes:
  - AND 00100100, OR 00100101, XOR 00100110, NOR 00100111.
  - SLL 01111100, SRL 00000010, SRA 00000011.
  - ADD 00100000, ADDU 00100001, SUB 00100010, SUBU 00100011.
  - SLT 00101010, SLTU 00101011.
  - MULT 00011000, MULTU 00011001.
  - DIV 00011010, DIVU 00011011.
- alusel encodings: LOGIC 001, SHIFT 010, ARITH 100, NOP 000.
- Result selection:
  - wdata_o takes the result of the class named by alusel_i.
  - Any other alusel value gives wdata_o = 0.
  - Unknown aluop gives 0.
- Shifts:
  - Value is reg2_i; amount is reg1_i[log2(WIDTH)-1:0].
  - SRA replicates the sign bit.
- Arithmetic:
  - ADD/SUB signed overflow forces wreg_o = 0; wdata_o still carries the truncated sum.
  - ADDU/SUBU never suppress the write.
  - SLT is a signed compare, SLTU unsigned; the result is 0 or 1.
- Multiply: MULT/MULTU give the full 2·WIDTH product; hi_o = upper half, lo_o = lower half, whilo_o = 1, same cycle.
- Divide results:
  - lo_o = quotient, truncated toward zero.
  - hi_o = remainder, carrying the sign of the dividend (reg1_i).
  - Divisor reg2_i == 0: lo_o = all-ones, hi_o = reg1_i, no iteration.
- Divider FSM states: IDLE, RUN, DONE.
  - IDLE: a DIV/DIVU with flush_i = 0 asserts stallreq_o combinationally. Divisor == 0 goes to DONE; otherwise to RUN, latching operand magnitudes and signs, with counter = 0.
  - RUN: one restoring shift-subtract step per cycle; stallreq_o = 1. After WIDTH steps, go to DONE.
  - DONE: stallreq_o = 0; apply sign fixup; drive hi_o/lo_o from the result registers with whilo_o = 1. Go to IDLE unconditionally; the same instruction never restarts.
- Flush:
  - flush_i = 1 in any state forces IDLE at the next edge.
  - flush_i = 1 forces stallreq_o = 0 and whilo_o = 0 combinationally.
- Reset:
  - rst == 0 at an edge: FSM goes to IDLE; counter and result registers clear.
  - While rst == 0, every output is driven 0 combinationally.
  - Reset mid-divide discards the divide.

## Timing
- Non-divide operations are combinational, zero latency.
- Divide, divisor ≠ 0:
  - stallreq_o is high for WIDTH+1 consecutive cycles (the issue cycle plus WIDTH RUN cycles).
  - Result appears in the DONE cycle, i.e. cycle WIDTH+2 counting the issue cycle as 1.
- Divide, divisor = 0: stallreq_o is high for 1 cycle; result appears in cycle 2.
- Inputs are held stable by the pipeline while stallreq_o = 1.
- Back-to-back divides: the second starts in the IDLE cycle after DONE.
- Reset values: FSM IDLE, stallreq_o 0, whilo_o 0, hi_o 0, lo_o 0, wdata_o 0, wreg_o 0, wd_o 0.

## Configuration
- EX_DIV_EN defined: divider FSM compiled in as above.
- EX_DIV_EN undefined:
  - DIV/DIVU behave as NOP: whilo_o = 0, hi_o = lo_o = 0, stallreq_o constantly 0.
  - No divider state is synthesised.

## Test plan
- OR 0x0000F0F0 | 0x00000F0F, alusel 001 -> wdata_o = 0x0000FFFF, wreg_o = wreg_i; alusel 000 -> wdata_o = 0.
- ADD 0x7FFFFFFF + 1, wreg_i = 1 -> wreg_o = 0; ADDU same operands -> wreg_o = 1, wdata_o = 0x80000000.
- SRA reg2 = 0x80000010, reg1 = 4 -> 0xF8000001; SLT -1 vs 1 -> 1; SLTU -1 vs 1 -> 0.
- MULT 0xFFFFFFFF × 2 -> hi_o = 0xFFFFFFFF, lo_o = 0xFFFFFFFE, whilo_o = 1, no stall.
- DIV -7 / 2 -> stall 33 cycles, then lo_o = 0xFFFFFFFD, hi_o = 0xFFFFFFFF; DIVU 7 / 0 -> 1 stall cycle, lo_o = 0xFFFFFFFF, hi_o = 7.
- DIVU 100 / 3: flush_i = 1 on RUN cycle 10 -> stallreq_o = 0 immediately, IDLE next edge, whilo_o never pulses; repeat with rst = 0 mid-RUN -> all outputs 0.
